pkt_rx_dequeue: RTL and testbench
=================================

// Module: pkt_rx_dequeue
// PURPOSE
//  Downstream consumer of the MAC POS-L3 receive interface. Watches pkt_rx_avail, drives
//  pkt_rx_ren, and captures words returned with pkt_rx_val into a credit-protected FIFO.
//  Presents the words on a valid/ready stream, checks framing and length, reports per-frame status.
// PARAMETERS
//  FIFO_DEPTH  16    output FIFO depth in 64-bit words; power of 2, >=4
//  MIN_BYTES   64    frames shorter than this are flagged bad
//  MAX_BYTES   1518  frames longer than this are flagged bad
// PORTS
//  clk_156m25    in   1   core clock, all logic on posedge
//  reset_156m25  in   1   synchronous, active-high reset
//  pkt_rx_avail  in   1   MAC has at least one complete frame queued
//  pkt_rx_ren    out  1   read enable to MAC; registered
//  pkt_rx_val    in   1   pkt_rx_* word valid; arrives 1 cycle after ren
//  pkt_rx_sop    in   1   first word of frame
//  pkt_rx_eop    in   1   last word of frame
//  pkt_rx_err    in   1   MAC error flag, qualified by val&&eop
//  pkt_rx_mod    in   3   valid bytes in eop word; 0 means 8
//  pkt_rx_data   in   64  receive data
//  out_valid     out  1   stream word valid
//  out_ready     in   1   downstream accepts word
//  out_data      out  64  stream data
//  out_sop/out_eop/out_err  out 1 each  framing flags carried with the word
//  out_mod       out  3   copy of pkt_rx_mod for the word
//  frame_done    out  1   one-cycle pulse: frame status valid
//  frame_len     out  14  byte count of finished frame; saturates at 16383
//  frame_bad     out  1   err | len<MIN_BYTES | len>MAX_BYTES | missing eop
//  frm_cnt/err_cnt/drop_cnt  out 32 each  good frames, bad frames, dropped stray words; wrap at 2^32
// BEHAVIOUR
//  Reset: ren=0, out_valid=0, frame_done=0, frame_len=0, frame_bad=0, all counters 0.
//   FIFO is flushed, in_frame=0, FSM=IDLE. Reset mid-frame discards all partial state.
//   ren is 0 in the cycle after reset is sampled.
//  FSM, 3 states:
//   IDLE: go to READ when pkt_rx_avail=1.
//   READ: ren_next = credit_ok. On val&&eop: ren_next=0 and go to GAP.
//   GAP: ren=0 for 1 cycle so that avail can update, then go to IDLE.
//  Credit: credit_ok = (occupancy + ren) <= FIFO_DEPTH-2, where ren is the current registered value.
//   Same-cycle pops are ignored (conservative). Any word with val=1 is always writable;
//   the FIFO never overflows.
//  Framing tracker; only words with val=1 are considered:
//   sop while !in_frame: start frame, len=0.
//   sop while in_frame: close previous frame with frame_bad=1 (missing eop), err_cnt++;
//    start new frame; the word is written normally.
//   !sop while !in_frame: word is not written; drop_cnt++.
//   sop&&eop in the same word: single-word frame.
//   Length accumulation: non-eop word adds 8; eop word adds (mod==0 ? 8 : mod).
//   On eop: frame_done=1 next cycle with frame_len and frame_bad. frm_cnt++ if good, else err_cnt++.
//    out_err=pkt_rx_err on the eop word. in_frame=0.
//   Words arriving after eop because of in-flight ren are tracked as above.
//  FIFO/stream:
//   Write at t is visible at t+1 (out_valid). Simultaneous push and pop is allowed at any occupancy.
//   out_* is held stable while out_valid && !out_ready. out_valid=0 only when the FIFO is empty.
// TESTING
//  1. 64B frame, 8 words, mod=0, out_ready=1 -> 8 stream words in order; frame_done len=64 bad=0; frm_cnt=1.
//  2. 65B frame, 9 words, eop mod=1 -> frame_len=65, bad=0; out_mod=1 on eop word.
//  3. 30-word frame, out_ready=0 for 40 cycles -> ren drops, occupancy never >16;
//     after release all 30 words delivered intact.
//  4. 64B frame with err=1 on eop -> out_err=1 on eop word, frame_bad=1, err_cnt=1, frm_cnt=0.
//  5. sop,data,sop(no eop),..,eop, then a stray !sop word -> one bad frame_done;
//     second frame reported; drop_cnt=1.
//  6. Assert reset during word 4 of 8 -> next cycle ren=0, out_valid=0, counters 0;
//     next clean 64B frame is reported good.

Source files
------------

// File: rtl/pkt_rx_dequeue.sv
// Pulls frames from the MAC POS-L3 receive port into a credit-protected FIFO and streams them out.
// Latency: a word is visible on out_* one cycle after pkt_rx_val; frame status one cycle after eop.
// Backpressure: out_ready stalls the FIFO, and credit accounting deasserts pkt_rx_ren before it fills.
module pkt_rx_dequeue #(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_BYTES  = 64,
  parameter int MAX_BYTES  = 1518
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic        pkt_rx_val,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic        pkt_rx_err,
  input  logic [2:0]  pkt_rx_mod,
  input  logic [63:0] pkt_rx_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [2:0]  out_mod,
  output logic        frame_done,
  output logic [13:0] frame_len,
  output logic        frame_bad,
  output logic [31:0] frm_cnt,
  output logic [31:0] err_cnt,
  output logic [31:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH - 2);
  localparam logic [13:0]   MIN_L      = 14'(MIN_BYTES);
  localparam logic [13:0]   MAX_L      = 14'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  mod;
  } word_t;

  state_t        state_q;
  logic          ren_q;
  word_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic          in_frame_q, in_frame_d;
  logic [13:0]   len_q, len_d;
  logic          done_q, done_d;
  logic [13:0]   flen_q, flen_d;
  logic          fbad_q, fbad_d;
  logic [31:0]   frm_q, err_q, drop_q;
  logic          frm_inc, drop_inc;
  logic [1:0]    err_inc;

  logic          push, pop, credit_ok;
  logic [CW-1:0] credit_sum;
  logic [3:0]    add_bytes;
  logic [13:0]   len_base, len_new;
  logic [14:0]   len_sum;
  logic          bad_new;
  word_t         word_in;

  // Credit ignores same-cycle pops; the word still in flight from ren_q is covered by the margin of two.
  assign credit_sum = occ_q + CW'(ren_q);
  assign credit_ok  = (credit_sum <= CREDIT_MAX);

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ren_q <= 1'b0;
          if (pkt_rx_avail) state_q <= READ;
        end
        READ: begin
          if (pkt_rx_val && pkt_rx_eop) begin
            ren_q   <= 1'b0;
            state_q <= GAP;
          end else begin
            ren_q <= credit_ok;
          end
        end
        GAP: begin
          ren_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ren_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign push    = pkt_rx_val && (pkt_rx_sop || in_frame_q);
  assign pop     = out_valid && out_ready;
  assign word_in = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                     err: pkt_rx_err && pkt_rx_eop, mod: pkt_rx_mod};

  always_ff @(posedge clk_156m25) begin
    if (push) mem_q[wr_ptr_q] <= word_in;
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_data  = mem_q[rd_ptr_q].data;
  assign out_sop   = mem_q[rd_ptr_q].sop;
  assign out_eop   = mem_q[rd_ptr_q].eop;
  assign out_err   = mem_q[rd_ptr_q].err;
  assign out_mod   = mem_q[rd_ptr_q].mod;

  // Length of the frame including the current word, saturating at 14 bits.
  assign add_bytes = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'd8;
  assign len_base  = pkt_rx_sop ? 14'd0 : len_q;
  assign len_sum   = {1'b0, len_base} + 15'(add_bytes);
  assign len_new   = len_sum[14] ? 14'h3FFF : len_sum[13:0];
  assign bad_new   = pkt_rx_err || (len_new < MIN_L) || (len_new > MAX_L);

  always_comb begin
    in_frame_d = in_frame_q;
    len_d      = len_q;
    done_d     = 1'b0;
    flen_d     = flen_q;
    fbad_d     = fbad_q;
    frm_inc    = 1'b0;
    err_inc    = 2'd0;
    drop_inc   = 1'b0;
    if (pkt_rx_val) begin
      if (pkt_rx_sop && in_frame_q) begin
        done_d  = 1'b1;
        flen_d  = len_q;
        fbad_d  = 1'b1;
        err_inc = 2'd1;
      end
      if (pkt_rx_sop || in_frame_q) begin
        if (pkt_rx_eop) begin
          done_d     = 1'b1;
          flen_d     = len_new;
          fbad_d     = bad_new;
          in_frame_d = 1'b0;
          if (bad_new) err_inc = err_inc + 2'd1;
          else         frm_inc = 1'b1;
        end else begin
          in_frame_d = 1'b1;
          len_d      = len_new;
        end
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      in_frame_q <= 1'b0;
      len_q      <= '0;
      done_q     <= 1'b0;
      flen_q     <= '0;
      fbad_q     <= 1'b0;
      frm_q      <= '0;
      err_q      <= '0;
      drop_q     <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      len_q      <= len_d;
      done_q     <= done_d;
      flen_q     <= flen_d;
      fbad_q     <= fbad_d;
      frm_q      <= frm_q + 32'(frm_inc);
      err_q      <= err_q + 32'(err_inc);
      drop_q     <= drop_q + 32'(drop_inc);
    end
  end

  assign pkt_rx_ren = ren_q;
  assign frame_done = done_q;
  assign frame_len  = flen_q;
  assign frame_bad  = fbad_q;
  assign frm_cnt    = frm_q;
  assign err_cnt    = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_pkt_rx_dequeue.sv
// Bench for pkt_rx_dequeue: MAC model feeding frames, scoreboarded output stream and frame reports.
module tb_pkt_rx_dequeue;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25;
  logic        pkt_rx_avail, pkt_rx_ren, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic [63:0] pkt_rx_data;
  logic        out_valid, out_ready, out_sop, out_eop, out_err;
  logic [63:0] out_data;
  logic [2:0]  out_mod;
  logic        frame_done, frame_bad;
  logic [13:0] frame_len;
  logic [31:0] frm_cnt, err_cnt, drop_cnt;

  pkt_rx_dequeue dut (
    .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop), .pkt_rx_err(pkt_rx_err),
    .pkt_rx_mod(pkt_rx_mod), .pkt_rx_data(pkt_rx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .out_mod(out_mod),
    .frame_done(frame_done), .frame_len(frame_len), .frame_bad(frame_bad),
    .frm_cnt(frm_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_156m25 = ~clk_156m25;

  typedef struct {
    logic [63:0] data;
    logic        sop, eop, err;
    logic [2:0]  mod;
    logic        kept;
  } mw_t;
  typedef struct { int len; logic bad; } fr_t;
  typedef struct { int nwords; int mod; int err; int stall; int exp_len; int exp_bad; } tv_t;

  mw_t mac_q[$];
  mw_t exp_stream[$];
  fr_t exp_frames[$];
  fr_t done_q[$];

  int  checks = 0, errors = 0;
  int  kept_cnt = 0, pop_cnt = 0, max_occ = 0, words_driven = 0;
  int  m_len = 0, exp_frm = 0, exp_err = 0, exp_drop = 0;
  bit  m_in_frame = 0;

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name, string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference model: frame accounting from the word-level framing rules.
  task automatic model_word(inout mw_t w);
    if (w.sop) begin
      if (m_in_frame) begin
        exp_frames.push_back('{len: m_len, bad: 1'b1});
        exp_err++;
      end
      m_in_frame = 1;
      m_len = 0;
    end
    if (!m_in_frame) begin
      w.kept = 0;
      exp_drop++;
    end else begin
      w.kept = 1;
      exp_stream.push_back(w);
      m_len += (w.eop && w.mod != 0) ? int'(w.mod) : 8;
      if (m_len > 16383) m_len = 16383;
      if (w.eop) begin
        fr_t r;
        r.len = m_len;
        r.bad = w.err || (m_len < 64) || (m_len > 1518);
        exp_frames.push_back(r);
        if (r.bad) exp_err++; else exp_frm++;
        m_in_frame = 0;
      end
    end
  endtask

  task automatic push_word(logic sop, logic eop, logic err, logic [2:0] mod);
    mw_t w;
    w.data = {$urandom, $urandom};
    w.sop = sop; w.eop = eop; w.err = eop ? err : 1'b0; w.mod = mod; w.kept = 0;
    model_word(w);
    mac_q.push_back(w);
  endtask

  task automatic send_frame(int n, int lastmod, bit err, bit has_eop);
    for (int i = 0; i < n; i++) begin
      logic last;
      last = has_eop && (i == n - 1);
      push_word(i == 0, last, err, last ? 3'(lastmod) : 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic model_clear();
    mac_q.delete(); exp_stream.delete(); exp_frames.delete(); done_q.delete();
    m_in_frame = 0; m_len = 0; exp_frm = 0; exp_err = 0; exp_drop = 0;
    kept_cnt = 0; pop_cnt = 0; max_occ = 0;
  endtask

  task automatic do_reset(string tag);
    reset_156m25 = 1'b1;
    out_ready = 1'b1;
    model_clear();
    @(posedge clk_156m25);
    @(negedge clk_156m25);
    chk({tag, "_ren"}, 80'(pkt_rx_ren), 80'(0));
    chk({tag, "_out_valid"}, 80'(out_valid), 80'(0));
    chk({tag, "_frame_done"}, 80'(frame_done), 80'(0));
    chk({tag, "_frame_len"}, 80'(frame_len), 80'(0));
    chk({tag, "_frame_bad"}, 80'(frame_bad), 80'(0));
    chk({tag, "_frm_cnt"}, 80'(frm_cnt), 80'(0));
    chk({tag, "_err_cnt"}, 80'(err_cnt), 80'(0));
    chk({tag, "_drop_cnt"}, 80'(drop_cnt), 80'(0));
    @(posedge clk_156m25); #2;
    reset_156m25 = 1'b0;
  endtask

  task automatic wait_report(string name, output fr_t r);
    int n = 0;
    r = '{len: -1, bad: 1'bx};
    while (done_q.size() == 0 && n < 5000) begin
      @(posedge clk_156m25); #2;
      n++;
    end
    if (done_q.size() == 0) fail(name, "no frame_done within 5000 cycles");
    else r = done_q.pop_front();
  endtask

  task automatic wait_drain(string name, bit rand_ready);
    int n = 0;
    while ((mac_q.size() != 0 || exp_stream.size() != 0) && n < 20000) begin
      @(posedge clk_156m25); #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    out_ready = 1'b1;
    if (mac_q.size() != 0 || exp_stream.size() != 0) fail(name, "stream did not drain within 20000 cycles");
    repeat (4) @(posedge clk_156m25);
    #2;
  endtask

  // MAC model: returns the next queued word one cycle after each sampled ren.
  initial begin
    bit  ren_prev = 0;
    mw_t w;
    pkt_rx_val = 0; pkt_rx_sop = 0; pkt_rx_eop = 0; pkt_rx_err = 0;
    pkt_rx_mod = 0; pkt_rx_data = 0; pkt_rx_avail = 0;
    forever begin
      @(posedge clk_156m25); #1;
      if (!reset_156m25 && ren_prev && mac_q.size() > 0) begin
        w = mac_q.pop_front();
        pkt_rx_val = 1; pkt_rx_sop = w.sop; pkt_rx_eop = w.eop; pkt_rx_err = w.err;
        pkt_rx_mod = w.mod; pkt_rx_data = w.data;
        if (w.kept) kept_cnt++;
        words_driven++;
      end else begin
        pkt_rx_val = 0; pkt_rx_sop = 0; pkt_rx_eop = 0; pkt_rx_err = 0;
        pkt_rx_mod = 3'($urandom); pkt_rx_data = {$urandom, $urandom};
      end
      ren_prev = reset_156m25 ? 1'b0 : pkt_rx_ren;
      pkt_rx_avail = !reset_156m25 && (mac_q.size() > 0);
    end
  end

  // Output monitor: stream scoreboard, hold-under-stall, frame report capture.
  initial begin
    bit          stall_prev = 0;
    logic [69:0] hold_vec = '0;
    mw_t         e;
    fr_t         r;
    forever begin
      @(negedge clk_156m25);
      if (reset_156m25) begin
        stall_prev = 0;
      end else begin
        if (stall_prev)
          chk("stall_hold", {9'd0, out_valid, out_data, out_sop, out_eop, out_err, out_mod},
              {9'd0, 1'b1, hold_vec});
        if (out_valid && out_ready) begin
          pop_cnt++;
          if (exp_stream.size() == 0) fail("stream_extra", "word delivered with none expected");
          else begin
            e = exp_stream.pop_front();
            chk("stream_word", 80'({out_data, out_sop, out_eop, out_err, out_mod}),
                80'({e.data, e.sop, e.eop, e.err, e.mod}));
          end
        end
        if (frame_done) begin
          r.len = int'(frame_len);
          r.bad = frame_bad;
          done_q.push_back(r);
        end
        if (kept_cnt - pop_cnt > max_occ) max_occ = kept_cnt - pop_cnt;
        stall_prev = out_valid && !out_ready;
        hold_vec = {out_data, out_sop, out_eop, out_err, out_mod};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t tbl [11];
    fr_t r;
    int  n_good = 0, n_bad = 0, base, nf, n;
    tbl[0]  = '{8,    0, 0, 0,  64,    0};
    tbl[1]  = '{9,    1, 0, 0,  65,    0};
    tbl[2]  = '{30,   0, 0, 40, 240,   0};
    tbl[3]  = '{8,    0, 1, 0,  64,    1};
    tbl[4]  = '{7,    0, 0, 0,  56,    1};
    tbl[5]  = '{8,    7, 0, 0,  63,    1};
    tbl[6]  = '{190,  6, 0, 0,  1518,  0};
    tbl[7]  = '{190,  7, 0, 0,  1519,  1};
    tbl[8]  = '{1,    0, 0, 0,  8,     1};
    tbl[9]  = '{1,    5, 0, 0,  5,     1};
    tbl[10] = '{2100, 0, 0, 0,  16383, 1};

    out_ready = 1'b1;
    do_reset("reset");

    for (int i = 0; i < 11; i++) begin
      out_ready = (tbl[i].stall == 0);
      send_frame(tbl[i].nwords, tbl[i].mod, tbl[i].err != 0, 1'b1);
      if (tbl[i].stall > 0) begin
        repeat (tbl[i].stall) @(posedge clk_156m25);
        @(negedge clk_156m25);
        chk("stall_ren_low", 80'(pkt_rx_ren), 80'(0));
        chk("stall_occ_le_16", 80'(max_occ > 16), 80'(0));
        @(posedge clk_156m25); #2;
        out_ready = 1'b1;
      end
      wait_report($sformatf("tv%0d_report", i), r);
      chk($sformatf("tv%0d_len", i), 80'(r.len), 80'(tbl[i].exp_len));
      chk($sformatf("tv%0d_bad", i), 80'(r.bad), 80'(tbl[i].exp_bad));
      wait_drain($sformatf("tv%0d_drain", i), 1'b0);
      if (tbl[i].exp_bad != 0) n_bad++; else n_good++;
    end
    chk("tv_frm_cnt", 80'(frm_cnt), 80'(n_good));
    chk("tv_err_cnt", 80'(err_cnt), 80'(n_bad));
    chk("tv_drop_cnt", 80'(drop_cnt), 80'(0));

    // Missing eop, then a good frame, then a stray word.
    send_frame(2, 0, 1'b0, 1'b0);
    send_frame(8, 0, 1'b0, 1'b1);
    push_word(1'b0, 1'b0, 1'b0, 3'd0);
    wait_report("noeop_report", r);
    chk("noeop_len", 80'(r.len), 80'(16));
    chk("noeop_bad", 80'(r.bad), 80'(1));
    wait_report("after_noeop_report", r);
    chk("after_noeop_len", 80'(r.len), 80'(64));
    chk("after_noeop_bad", 80'(r.bad), 80'(0));
    wait_drain("noeop_drain", 1'b0);
    chk("noeop_drop_cnt", 80'(drop_cnt), 80'(1));
    chk("noeop_err_cnt", 80'(err_cnt), 80'(n_bad + 1));
    chk("noeop_frm_cnt", 80'(frm_cnt), 80'(n_good + 1));

    // Reset in the middle of a frame.
    base = words_driven;
    send_frame(8, 0, 1'b0, 1'b1);
    n = 0;
    while (words_driven < base + 4 && n < 200) begin
      @(posedge clk_156m25); #2;
      n++;
    end
    if (words_driven < base + 4) fail("midreset_wait", "word 4 never driven");
    do_reset("midreset");
    send_frame(8, 0, 1'b0, 1'b1);
    wait_report("post_reset_report", r);
    chk("post_reset_len", 80'(r.len), 80'(64));
    chk("post_reset_bad", 80'(r.bad), 80'(0));
    wait_drain("post_reset_drain", 1'b0);
    chk("post_reset_frm_cnt", 80'(frm_cnt), 80'(1));
    chk("post_reset_err_cnt", 80'(err_cnt), 80'(0));

    // Randomized traffic against the reference model.
    exp_frames.delete();
    done_q.delete();
    for (int f = 0; f < 40; f++) begin
      int  nw;
      bit  has_eop;
      nw = $urandom_range(1, 20);
      if (m_in_frame && nw < 2) nw = 2;
      has_eop = (f == 39) || ($urandom_range(0, 9) != 0);
      send_frame(nw, $urandom_range(0, 7), $urandom_range(0, 7) == 0, has_eop);
      if ($urandom_range(0, 7) == 0) push_word(1'b0, 1'b0, 1'b0, 3'($urandom));
    end
    wait_drain("rand_drain", 1'b1);
    chk("rand_report_count", 80'(done_q.size()), 80'(exp_frames.size()));
    nf = (done_q.size() < exp_frames.size()) ? done_q.size() : exp_frames.size();
    for (int i = 0; i < nf; i++) begin
      chk($sformatf("rand_len%0d", i), 80'(done_q[i].len), 80'(exp_frames[i].len));
      chk($sformatf("rand_bad%0d", i), 80'(done_q[i].bad), 80'(exp_frames[i].bad));
    end
    chk("rand_frm_cnt", 80'(frm_cnt), 80'(exp_frm));
    chk("rand_err_cnt", 80'(err_cnt), 80'(exp_err));
    chk("rand_drop_cnt", 80'(drop_cnt), 80'(exp_drop));
    chk("rand_occ_le_16", 80'(max_occ > 16), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
